// File: rtl/serv_bus_arbiter_pkg.sv
// Shared types for the SERV instruction/data bus arbiter.
// The state encoding is fixed because it also appears in the core-wide parameter header.
package serv_bus_arbiter_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_I  = 2'd1,
        ARB_GNT_D  = 2'd2,
        ARB_RETIRE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
    } wb_req_t;

    function automatic logic is_grant(arb_state_e s);
        return (s == ARB_GNT_I) || (s == ARB_GNT_D);
    endfunction

endpackage

// File: rtl/serv_bus_arbiter_watchdog.sv
// Saturating grant-cycle counter; flags a transfer that has been held for TIMEOUT_CYCLES cycles.
// TIMEOUT_CYCLES = 0 disables the hit output entirely.
module serv_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign o_hit = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master port between the SERV ibus and dbus.
// Registered grant, one transfer in flight, dbus has priority, watchdog-terminated stalls.
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_bus_fault
);

    arb_state_e state;
    arb_state_e state_next;

    logic    in_gnt;
    logic    wd_hit;
    logic    master_cyc;
    logic    term;
    logic    done;
    logic    fault;
    logic    done_rdt_ok;
    wb_req_t req;

    assign in_gnt = is_grant(state);

    // Counter is held at zero outside a grant, so every grant starts from 0.
    serv_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_wd (
        .clk   (clk),
        .i_rst (i_rst),
        .i_clr (!in_gnt),
        .i_en  (in_gnt),
        .o_hit (wd_hit)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req         = '0;
        master_cyc  = 1'b0;
        o_wb_cyc    = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (i_dbus_cyc) begin
                    state_next = ARB_GNT_D;
                end else if (i_ibus_cyc) begin
                    state_next = ARB_GNT_I;
                end
            end
            ARB_GNT_I: begin
                req.adr    = i_ibus_adr;
                req.dat    = '0;
                req.sel    = 4'hF;
                req.we     = 1'b0;
                master_cyc = i_ibus_cyc;
                o_wb_cyc   = 1'b1;
            end
            ARB_GNT_D: begin
                req.adr    = i_dbus_adr;
                req.dat    = i_dbus_dat;
                req.sel    = i_dbus_sel;
                req.we     = i_dbus_we;
                master_cyc = i_dbus_cyc;
                o_wb_cyc   = 1'b1;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        // A master abandoning its request also retires the grant, silently.
        term = in_gnt && (i_wb_ack || i_wb_err || wd_hit);
        if (in_gnt && (term || !master_cyc)) begin
            state_next = ARB_RETIRE;
        end
    end

    assign done        = term && master_cyc;
    assign fault       = done && !i_wb_ack;
    assign done_rdt_ok = done && i_wb_ack;

    assign o_wb_adr    = req.adr;
    assign o_wb_dat    = req.dat;
    assign o_wb_sel    = req.sel;
    assign o_wb_we     = req.we;

    assign o_ibus_ack  = done && (state == ARB_GNT_I);
    assign o_dbus_ack  = done && (state == ARB_GNT_D);
    assign o_ibus_rdt  = (done_rdt_ok && (state == ARB_GNT_I)) ? i_wb_rdt : 32'h0;
    assign o_dbus_rdt  = (done_rdt_ok && (state == ARB_GNT_D)) ? i_wb_rdt : 32'h0;
    assign o_bus_fault = fault;

endmodule
